// File: rtl/ctrl_regfile_core.sv
// Decode, two-stage pipeline and 32x16 register file of the 16-bit RISC core.
// Optional macro REGFILE_R0_ZERO_EN: register 0 reads as zero and ignores writes.
module ctrl_regfile_core #(
   parameter int unsigned NREGS = 32,
   parameter int unsigned DW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   instr,
   input  logic          p_Z,
   input  logic [DW-1:0] write_bus,
   output tri   [DW-1:0] R1_bus,
   output tri   [DW-1:0] R2_bus,
   output logic [15:0]   instr_stage1,
   output logic [15:0]   instr_stage2,
   output logic          ALU_en,
   output logic          rR1_en,
   output logic          rR2_en,
   output logic          mov_en,
   output logic          SI_en,
   output logic          Datar_en,
   output logic          iRW_regw_en,
   output logic          SP_load_en,
   output logic          dcr_SP,
   output logic          SPr,
   output logic          Regw_en,
   output logic          ALU_write_en,
   output logic          iRW_regr_en,
   output logic          Dataw_en,
   output logic          PC_load_en,
   output logic          R_nJ,
   output logic          inr_SP,
   output logic          SPw,
   output logic          hlt
);

   localparam int unsigned AW = 5;

   logic [15:0]   r_stage1;
   logic [15:0]   r_stage2;
   logic [DW-1:0] r_regs [NREGS];

   logic [2:0]    w_op1, w_f1, w_op2, w_f2;
   logic [AW-1:0] w_rd1_addr, w_rd2_addr, w_wr_addr;
   logic [DW-1:0] w_rd1_data, w_rd2_data;
   logic          w_wr_ok;

   assign instr_stage1 = r_stage1;
   assign instr_stage2 = r_stage2;
   assign w_op1        = r_stage1[15:13];
   assign w_f1         = r_stage1[2:0];
   assign w_op2        = r_stage2[15:13];
   assign w_f2         = r_stage2[2:0];
   assign w_rd1_addr   = r_stage1[12:8];
   assign w_rd2_addr   = r_stage1[7:3];
   assign w_wr_addr    = r_stage2[12:8];

   // Instruction pipeline; reset injects NOPs into both stages
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stage1 <= 16'h0000;
         r_stage2 <= 16'h0000;
      end else begin
         r_stage1 <= instr;
         r_stage2 <= r_stage1;
      end
   end

   // Stage-1 decode: operand reads, memory reads, stack pre-decrement
   always_comb begin
      ALU_en      = 1'b0;
      rR1_en      = 1'b0;
      rR2_en      = 1'b0;
      mov_en      = 1'b0;
      SI_en       = 1'b0;
      Datar_en    = 1'b0;
      iRW_regw_en = 1'b0;
      SP_load_en  = 1'b0;
      dcr_SP      = 1'b0;
      SPr         = 1'b0;
      case (w_op1)
         3'b000: begin
            case (w_f1)
               3'b001: begin rR2_en = 1'b1; mov_en = 1'b1; iRW_regw_en = 1'b1; end
               3'b010: begin SPr = 1'b1; Datar_en = 1'b1; iRW_regw_en = 1'b1; end
               3'b100: SP_load_en = 1'b1;
               default: ;
            endcase
         end
         3'b001: begin
            rR1_en = 1'b1;
            rR2_en = 1'b1;
            ALU_en = 1'b1;
            SI_en  = ((w_f1 == 3'b010) || (w_f1 == 3'b011)) && r_stage1[3];
         end
         3'b100: begin Datar_en = 1'b1; iRW_regw_en = 1'b1; end
         3'b101: begin rR1_en = 1'b1; iRW_regw_en = 1'b1; end
         3'b111: dcr_SP = 1'b1;
         default: ;
      endcase
   end

   // Stage-2 decode: write-back, stores, branches, stack post-increment, halt
   always_comb begin
      Regw_en      = 1'b0;
      ALU_write_en = 1'b0;
      iRW_regr_en  = 1'b0;
      Dataw_en     = 1'b0;
      PC_load_en   = 1'b0;
      R_nJ         = 1'b0;
      inr_SP       = 1'b0;
      SPw          = 1'b0;
      hlt          = 1'b0;
      case (w_op2)
         3'b000: begin
            case (w_f2)
               3'b001: begin iRW_regr_en = 1'b1; Regw_en = 1'b1; end
               3'b010: begin
                  iRW_regr_en = 1'b1;
                  R_nJ        = 1'b1;
                  PC_load_en  = 1'b1;
                  inr_SP      = 1'b1;
               end
               3'b111: hlt = 1'b1;
               default: ;
            endcase
         end
         3'b001: begin ALU_write_en = 1'b1; Regw_en = 1'b1; end
         3'b010: PC_load_en = p_Z;
         3'b011: PC_load_en = !p_Z;
         3'b100: begin iRW_regr_en = 1'b1; Regw_en = 1'b1; end
         3'b101: begin iRW_regr_en = 1'b1; Dataw_en = 1'b1; end
         3'b110: PC_load_en = 1'b1;
         3'b111: begin SPw = 1'b1; Dataw_en = 1'b1; PC_load_en = 1'b1; end
         default: ;
      endcase
   end

`ifdef REGFILE_R0_ZERO_EN
   assign w_wr_ok    = Regw_en && (w_wr_addr != AW'(0));
   assign w_rd1_data = (w_rd1_addr == AW'(0)) ? DW'(0) : r_regs[w_rd1_addr];
   assign w_rd2_data = (w_rd2_addr == AW'(0)) ? DW'(0) : r_regs[w_rd2_addr];
`else
   assign w_wr_ok    = Regw_en;
   assign w_rd1_data = r_regs[w_rd1_addr];
   assign w_rd2_data = r_regs[w_rd2_addr];
`endif

   // Register file; reads see the pre-edge value (no write bypass)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= DW'(0);
      end else if (w_wr_ok) begin
         r_regs[w_wr_addr] <= write_bus;
      end
   end

   assign R1_bus = rR1_en ? w_rd1_data : {DW{1'bz}};
   assign R2_bus = rR2_en ? w_rd2_data : {DW{1'bz}};

endmodule

// File: tb/tb_ctrl_regfile_core.sv
// Self-checking bench for ctrl_regfile_core: directed scenarios plus random
// instruction streams against an instruction-level model of the pipeline.
module tb_ctrl_regfile_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        p_Z;
   logic [15:0] write_bus;
   wire  [15:0] R1_bus, R2_bus;
   logic [15:0] instr_stage1, instr_stage2;
   logic ALU_en, rR1_en, rR2_en, mov_en, SI_en, Datar_en, iRW_regw_en, SP_load_en, dcr_SP, SPr;
   logic Regw_en, ALU_write_en, iRW_regr_en, Dataw_en, PC_load_en, R_nJ, inr_SP, SPw, hlt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ctrl_regfile_core dut (
      .clk(clk), .reset(reset), .instr(instr), .p_Z(p_Z), .write_bus(write_bus),
      .R1_bus(R1_bus), .R2_bus(R2_bus),
      .instr_stage1(instr_stage1), .instr_stage2(instr_stage2),
      .ALU_en(ALU_en), .rR1_en(rR1_en), .rR2_en(rR2_en), .mov_en(mov_en), .SI_en(SI_en),
      .Datar_en(Datar_en), .iRW_regw_en(iRW_regw_en), .SP_load_en(SP_load_en),
      .dcr_SP(dcr_SP), .SPr(SPr),
      .Regw_en(Regw_en), .ALU_write_en(ALU_write_en), .iRW_regr_en(iRW_regr_en),
      .Dataw_en(Dataw_en), .PC_load_en(PC_load_en), .R_nJ(R_nJ), .inr_SP(inr_SP),
      .SPw(SPw), .hlt(hlt)
   );

   // Control vectors, named bit positions
   localparam int ALU = 9, RR1 = 8, RR2 = 7, MOV = 6, SI = 5, DATR = 4, IRWW = 3, SPL = 2, DCR = 1, SPRD = 0;
   localparam int REGW = 8, ALUW = 7, IRWR = 6, DATW = 5, PCL = 4, RNJ = 3, INR = 2, SPWR = 1, HLT = 0;

   wire [9:0] s1_ctl = {ALU_en, rR1_en, rR2_en, mov_en, SI_en, Datar_en, iRW_regw_en, SP_load_en, dcr_SP, SPr};
   wire [8:0] s2_ctl = {Regw_en, ALU_write_en, iRW_regr_en, Dataw_en, PC_load_en, R_nJ, inr_SP, SPw, hlt};

   typedef enum {I_NOP, I_MOV, I_RET, I_LDSP, I_HLT, I_ALU, I_JZ, I_JNZ, I_LD, I_ST, I_JMP, I_CALL} mnem_t;

   // Reference model state
   logic [15:0] m_s1, m_s2;
   logic [15:0] m_regs [32];

   function automatic mnem_t classify(input logic [15:0] i);
      logic [2:0] op, f;
      op = i[15:13];
      f  = i[2:0];
      if (op == 3'd0) begin
         if (f == 3'd1) return I_MOV;
         if (f == 3'd2) return I_RET;
         if (f == 3'd4) return I_LDSP;
         if (f == 3'd7) return I_HLT;
         return I_NOP;
      end
      case (op)
         3'd1: return I_ALU;
         3'd2: return I_JZ;
         3'd3: return I_JNZ;
         3'd4: return I_LD;
         3'd5: return I_ST;
         3'd6: return I_JMP;
         default: return I_CALL;
      endcase
   endfunction

   function automatic logic [9:0] exp_s1(input logic [15:0] i);
      logic [9:0] v;
      v = '0;
      case (classify(i))
         I_MOV:  begin v[RR2] = 1; v[MOV] = 1; v[IRWW] = 1; end
         I_RET:  begin v[SPRD] = 1; v[DATR] = 1; v[IRWW] = 1; end
         I_LDSP: v[SPL] = 1;
         I_ALU:  begin
            v[RR1] = 1; v[RR2] = 1; v[ALU] = 1;
            v[SI]  = (i[2:0] == 3'd2 || i[2:0] == 3'd3) && i[3];
         end
         I_LD:   begin v[DATR] = 1; v[IRWW] = 1; end
         I_ST:   begin v[RR1] = 1; v[IRWW] = 1; end
         I_CALL: v[DCR] = 1;
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [8:0] exp_s2(input logic [15:0] i, input logic z);
      logic [8:0] v;
      v = '0;
      case (classify(i))
         I_MOV:  begin v[IRWR] = 1; v[REGW] = 1; end
         I_RET:  begin v[IRWR] = 1; v[RNJ] = 1; v[PCL] = 1; v[INR] = 1; end
         I_HLT:  v[HLT] = 1;
         I_ALU:  begin v[ALUW] = 1; v[REGW] = 1; end
         I_JZ:   v[PCL] = z;
         I_JNZ:  v[PCL] = !z;
         I_LD:   begin v[IRWR] = 1; v[REGW] = 1; end
         I_ST:   begin v[IRWR] = 1; v[DATW] = 1; end
         I_JMP:  v[PCL] = 1;
         I_CALL: begin v[SPWR] = 1; v[DATW] = 1; v[PCL] = 1; end
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [15:0] m_read(input logic [4:0] a);
`ifdef REGFILE_R0_ZERO_EN
      if (a == 5'd0) return 16'h0000;
`endif
      return m_regs[a];
   endfunction

   task automatic model_reset();
      m_s1 = 16'h0000;
      m_s2 = 16'h0000;
      for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
   endtask

   // Drive inputs, clock once, advance the model; sampling is 1 ns after the edge
   task automatic cycle(input logic [15:0] in, input logic [15:0] wb, input logic z);
      logic [8:0] c2;
      instr     = in;
      write_bus = wb;
      p_Z       = z;
      @(posedge clk);
      c2 = exp_s2(m_s2, z);
      if (c2[REGW]) begin
`ifdef REGFILE_R0_ZERO_EN
         if (m_s2[12:8] != 5'd0) m_regs[m_s2[12:8]] = wb;
`else
         m_regs[m_s2[12:8]] = wb;
`endif
      end
      m_s2 = m_s1;
      m_s1 = in;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      instr = 16'hFFFF;
      p_Z = 1'b1;
      write_bus = 16'hFFFF;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      n_tests++;
      if (instr_stage1 !== 16'h0000 || instr_stage2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_stages: got %h/%h want 0000/0000", instr_stage1, instr_stage2);
      end
      n_tests++;
      if (s1_ctl !== 10'd0 || s2_ctl !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_ctl: got s1=%b s2=%b want all zero", s1_ctl, s2_ctl);
      end
      reset = 1'b1;
      // ALU Rd=Rs=i reads both ports of every register; write-backs carry 0
      for (int i = 0; i < 32; i++) begin
         cycle({3'b001, 5'(i), 5'(i), 3'b000}, 16'h0000, 1'b0);
         n_tests++;
         if (R1_bus !== 16'h0000 || R2_bus !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h/%h want 0000", i, R1_bus, R2_bus);
         end
      end
      cycle(16'h0000, 16'h0000, 1'b0);
      cycle(16'h0000, 16'h0000, 1'b0);
      n_tests++;
      if (s1_ctl !== 10'd0 || s2_ctl !== 9'd0) begin
         n_fail++;
         $display("FAIL nop_idle: got s1=%b s2=%b want all zero", s1_ctl, s2_ctl);
      end
   endtask

   task automatic test_alu();
      cycle(16'h2110, 16'h0000, 1'b0);
      n_tests++;
      if ({rR1_en, rR2_en, ALU_en, SI_en} !== 4'b1110 || instr_stage1 !== 16'h2110) begin
         n_fail++;
         $display("FAIL alu_s1: got rR1 rR2 ALU SI=%b want 1110", {rR1_en, rR2_en, ALU_en, SI_en});
      end
      cycle(16'h0000, 16'h0000, 1'b0);
      n_tests++;
      if ({ALU_write_en, Regw_en} !== 2'b11 || instr_stage2 !== 16'h2110) begin
         n_fail++;
         $display("FAIL alu_s2: got ALU_write Regw=%b want 11", {ALU_write_en, Regw_en});
      end
      cycle(16'hA100, 16'h1234, 1'b0);
      n_tests++;
      if (R1_bus !== 16'h1234) begin
         n_fail++;
         $display("FAIL alu_wb: got R1=%h want 1234", R1_bus);
      end
   endtask

   task automatic test_serial_rotate();
      cycle(16'h240A, 16'h0000, 1'b0);
      n_tests++;
      if (SI_en !== 1'b1) begin
         n_fail++;
         $display("FAIL si_on: got %b want 1", SI_en);
      end
      cycle(16'h2402, 16'h0000, 1'b0);
      n_tests++;
      if (SI_en !== 1'b0) begin
         n_fail++;
         $display("FAIL si_off: got %b want 0", SI_en);
      end
      cycle(16'h0000, 16'h0000, 1'b0);
      cycle(16'h0000, 16'h0000, 1'b0);
   endtask

   task automatic test_load();
      cycle(16'h8340, 16'h0000, 1'b0);
      n_tests++;
      if ({Datar_en, iRW_regw_en} !== 2'b11) begin
         n_fail++;
         $display("FAIL ld_s1: got Datar iRW_regw=%b want 11", {Datar_en, iRW_regw_en});
      end
      cycle(16'h0000, 16'h0000, 1'b0);
      n_tests++;
      if ({iRW_regr_en, Regw_en} !== 2'b11 || instr_stage2[12:8] !== 5'd3) begin
         n_fail++;
         $display("FAIL ld_s2: got iRW_regr Regw=%b addr=%0d want 11 addr 3",
                  {iRW_regr_en, Regw_en}, instr_stage2[12:8]);
      end
      cycle(16'hA300, 16'hBEEF, 1'b0);
      n_tests++;
      if (R1_bus !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL ld_wb: got R3=%h want beef", R1_bus);
      end
   endtask

   task automatic test_branches();
      cycle(16'h4123, 16'h0000, 1'b0);
      cycle(16'h6123, 16'h0000, 1'b1);
      n_tests++;
      if (PC_load_en !== 1'b1) begin
         n_fail++;
         $display("FAIL jz_taken: got %b want 1", PC_load_en);
      end
      p_Z = 1'b0;
      #1;
      n_tests++;
      if (PC_load_en !== 1'b0) begin
         n_fail++;
         $display("FAIL jz_not_taken: got %b want 0", PC_load_en);
      end
      cycle(16'h0000, 16'h0000, 1'b0);
      n_tests++;
      if (PC_load_en !== 1'b1) begin
         n_fail++;
         $display("FAIL jnz_taken: got %b want 1", PC_load_en);
      end
      p_Z = 1'b1;
      #1;
      n_tests++;
      if (PC_load_en !== 1'b0) begin
         n_fail++;
         $display("FAIL jnz_not_taken: got %b want 0", PC_load_en);
      end
   endtask

   task automatic test_sp_halt();
      cycle(16'h07F4, 16'h0000, 1'b0);
      n_tests++;
      if (SP_load_en !== 1'b1) begin
         n_fail++;
         $display("FAIL ldsp: got %b want 1", SP_load_en);
      end
      cycle(16'h0007, 16'h0000, 1'b0);
      n_tests++;
      if (hlt !== 1'b0) begin
         n_fail++;
         $display("FAIL hlt_early: got %b want 0", hlt);
      end
      cycle(16'h0000, 16'h0000, 1'b0);
      n_tests++;
      if (hlt !== 1'b1) begin
         n_fail++;
         $display("FAIL hlt_s2: got %b want 1", hlt);
      end
      cycle(16'h0000, 16'h0000, 1'b0);
      n_tests++;
      if (hlt !== 1'b0) begin
         n_fail++;
         $display("FAIL hlt_late: got %b want 0", hlt);
      end
      cycle(16'hE123, 16'h0000, 1'b0);
      cycle(16'h0000, 16'h0000, 1'b0);
      n_tests++;
      if ({SPw, Dataw_en, PC_load_en} !== 3'b111) begin
         n_fail++;
         $display("FAIL call_s2: got %b want 111", {SPw, Dataw_en, PC_load_en});
      end
      reset = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({SPw, Dataw_en, PC_load_en} !== 3'b000 || instr_stage2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL call_reset: got %b stage2=%h want 000 0000", {SPw, Dataw_en, PC_load_en}, instr_stage2);
      end
      #2;
      reset = 1'b1;
   endtask

   task automatic test_random();
      logic [15:0] in;
      for (int n = 0; n < 400; n++) begin
         in = 16'($urandom);
         if ($urandom_range(0, 3) == 0) in[15:13] = 3'b000;
         cycle(in, 16'($urandom), 1'($urandom));
         n_tests++;
         if (instr_stage1 !== m_s1 || instr_stage2 !== m_s2) begin
            n_fail++;
            $display("FAIL rnd_stage[%0d]: got %h/%h want %h/%h", n, instr_stage1, instr_stage2, m_s1, m_s2);
         end
         n_tests++;
         if (s1_ctl !== exp_s1(m_s1) || s2_ctl !== exp_s2(m_s2, p_Z)) begin
            n_fail++;
            $display("FAIL rnd_ctl[%0d]: got %b/%b want %b/%b", n, s1_ctl, s2_ctl,
                     exp_s1(m_s1), exp_s2(m_s2, p_Z));
         end
         if (exp_s1(m_s1)[RR1]) begin
            n_tests++;
            if (R1_bus !== m_read(m_s1[12:8])) begin
               n_fail++;
               $display("FAIL rnd_r1[%0d]: got %h want %h", n, R1_bus, m_read(m_s1[12:8]));
            end
         end
         if (exp_s1(m_s1)[RR2]) begin
            n_tests++;
            if (R2_bus !== m_read(m_s1[7:3])) begin
               n_fail++;
               $display("FAIL rnd_r2[%0d]: got %h want %h", n, R2_bus, m_read(m_s1[7:3]));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_serial_rotate();
      test_load();
      test_branches();
      test_sp_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
